// File: rtl/riscv_loader_pkg.sv
// riscv_loader_pkg: shared types and frame constants for the imem program loader
package riscv_loader_pkg;
    localparam int DEF_MAX_WORDS = 256;
    localparam int DEF_CNT_W     = 16;
    localparam int HDR_BYTES     = 2;
    localparam int WORD_BYTES    = 4;
    localparam int CSUM_BYTES    = 1;
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR} loader_state_t;
    function automatic logic hdr_ok(input logic [DEF_CNT_W-1:0] n, input logic [DEF_CNT_W-1:0] max_words);
        return n != '0 && n <= max_words;
    endfunction
endpackage

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: host byte stream in, imem write port out
interface imem_program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] Imem_write_instr;
    logic        Imem_write_en;
    logic [7:0]  imem_wr_addr;
    modport master (output byte_valid, byte_data, input byte_ready, Imem_write_instr, Imem_write_en, imem_wr_addr);
    modport slave  (input byte_valid, byte_data, output byte_ready, Imem_write_instr, Imem_write_en, imem_wr_addr);
endinterface

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: little-endian byte-to-word packing with running XOR checksum
module loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done,
    output logic [7:0]  csum
);
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            byte_idx <= '0;
            word_q   <= '0;
            csum     <= '0;
        end else if (en) begin
            byte_idx                         <= byte_idx + 2'd1;
            word_q[{byte_idx, 3'b000} +: 8]  <= byte_data;
            csum                             <= csum ^ byte_data;
        end
    end
    // The final byte is merged combinationally so the word is ready on its own handshake
    assign word      = {byte_data, word_q[23:0]};
    assign word_done = en && byte_idx == 2'd3;
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte stream to sequential imem writes, releases the core on a good checksum
module imem_program_loader
    import riscv_loader_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_program_loader_if.slave  bus,
    output logic [CNT_W-1:0]      words_loaded,
    output logic                  start,
    output logic                  load_error
);
    loader_state_t     state, state_nxt;
    logic              xfer, word_done, last_word;
    logic [7:0]        n_lo, csum;
    logic [31:0]       word;
    logic [CNT_W-1:0]  n, n_hdr;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign n_hdr     = CNT_W'({bus.byte_data, n_lo});
    assign last_word = words_loaded == n - CNT_W'(1);

    loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == HDR_HI && xfer),
        .en        (state == DATA && xfer),
        .byte_data (bus.byte_data),
        .word      (word),
        .word_done (word_done),
        .csum      (csum)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= HDR_LO;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR_LO:  state_nxt = xfer ? HDR_HI : state;
            HDR_HI:  state_nxt = !xfer ? state : hdr_ok(n_hdr, CNT_W'(MAX_WORDS)) ? DATA : ERROR;
            DATA:    state_nxt = (word_done && last_word) ? CSUM : state;
            CSUM:    state_nxt = !xfer ? state : (bus.byte_data == csum) ? DONE : ERROR;
            default: state_nxt = state;
        endcase
    end

    // Ready is gated by reset so nothing is accepted while reset is held
    always_comb begin
        bus.byte_ready = reset && (state inside {HDR_LO, HDR_HI, DATA, CSUM});
        start          = state == DONE;
        load_error     = state == ERROR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            n_lo                 <= '0;
            n                    <= '0;
            bus.Imem_write_instr <= '0;
            bus.Imem_write_en    <= 1'b0;
            bus.imem_wr_addr     <= '0;
            words_loaded         <= '0;
        end else begin
            if (state == HDR_LO && xfer) n_lo <= bus.byte_data;
            if (state == HDR_HI && xfer) n <= n_hdr;
            bus.Imem_write_en <= word_done;
            if (word_done) begin
                bus.Imem_write_instr <= word;
                bus.imem_wr_addr     <= words_loaded[7:0];
            end
            if (bus.Imem_write_en) words_loaded <= words_loaded + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed frames against hand-computed imem writes and status
module tb_imem_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] words_loaded;
    logic        start, load_error;
    int          tests = 0;
    int          fails = 0;
    bit          ok;
    logic [31:0] wr_data[$];
    logic [7:0]  wr_addr[$];
    logic [7:0]  good[$]  = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
    logic [7:0]  badcs[$] = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h11};
    logic [31:0] exp_data[2] = '{32'h00500113, 32'h00C00193};

    imem_program_loader_if bus();

    imem_program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .words_loaded (words_loaded),
        .start        (start),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.Imem_write_en) begin
            wr_data.push_back(bus.Imem_write_instr);
            wr_addr.push_back(bus.imem_wr_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        wr_data.delete();
        wr_addr.delete();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit done);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.byte_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps);
        bit h;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], gaps ? int'($urandom_range(0, 3)) : 0, h);
            check("handshake", 32'(h), 32'd1);
            if (!h) break;
            if (i >= 2 && i < f.size() - 1 && (i - 2) % 4 == 3)
                check("strobe_latency", 32'(bus.Imem_write_en), 32'd1);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_data.size()), 32'd2);
        for (int i = 0; i < 2 && i < wr_data.size(); i++) begin
            check({tag, "_wr_data"}, wr_data[i], exp_data[i]);
            check({tag, "_wr_addr"}, 32'(wr_addr[i]), 32'(i));
        end
    endtask

    task automatic check_good(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_start"}, 32'(start), 32'd1);
        check({tag, "_err"}, 32'(load_error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd2);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check_writes(tag);
    endtask

    task automatic bad_header(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        do_reset();
        send_byte(lo, 0, ok);
        send_byte(hi, 0, ok);
        check({tag, "_err"}, 32'(load_error), 32'd1);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_no_write"}, 32'(wr_data.size()), 32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wen", 32'(bus.Imem_write_en), 32'd0);
        check("rst_instr", bus.Imem_write_instr, 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.byte_ready), 32'd1);

        send_frame(good, 1'b0);
        check_good("good");

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hAA;
            check("done_ready", 32'(bus.byte_ready), 32'd0);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check("done_words", 32'(words_loaded), 32'd2);
        check("done_start", 32'(start), 32'd1);
        check("done_wr_count", 32'(wr_data.size()), 32'd2);

        do_reset();
        send_frame(badcs, 1'b0);
        repeat (2) @(negedge clk);
        check("badcs_err", 32'(load_error), 32'd1);
        check("badcs_start", 32'(start), 32'd0);
        check("badcs_ready", 32'(bus.byte_ready), 32'd0);
        check_writes("badcs");

        bad_header("n0", 8'h00, 8'h00);
        bad_header("n257", 8'h01, 8'h01);

        do_reset();
        send_frame(good, 1'b1);
        check_good("gaps");

        do_reset();
        for (int i = 0; i < 8; i++) send_byte(good[i], 0, ok);
        do_reset();
        check("abort_words", 32'(words_loaded), 32'd0);
        check("abort_no_write", 32'(wr_data.size()), 32'd0);
        send_frame(good, 1'b0);
        check_good("abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
